// File: rtl/energy_monitor_pkg.sv
// Shared types and default sizing for the energy monitor datapath.
package energy_monitor_pkg;

  // Default packer geometry: 256 eight-bit words per frame, four words per beat.
  localparam int DEFAULT_N     = 256;
  localparam int DEFAULT_DATAW = 8;
  localparam int DEFAULT_LANES = 4;

  // Packer FSM: FILL collects beats, EMIT is the single frame-complete cycle.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } packer_state_t;

endpackage : energy_monitor_pkg

// File: rtl/energy_operand_packer.sv
// Packs LANES-wide input beats into one N-word frame for the adder tree.
// Handshake: a beat transfers on a rising clk_i edge where in_valid_i and
// in_ready_o are both high (and flush_i is low); in_ready_o never depends on
// in_valid_i. data_valid_o is a one-cycle strobe with no back-pressure.
module energy_operand_packer
  import energy_monitor_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int DATAW     = DEFAULT_DATAW,
  parameter int LANES     = DEFAULT_LANES,
  parameter int OUT_WIDTH = N * DATAW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*DATAW-1:0] in_data_i,
  input  logic                   in_last_i,
  output logic [OUT_WIDTH-1:0]   data_o,
  output logic                   data_valid_o,
  output logic                   busy_o
);

  localparam int BEATS  = N / LANES;
  localparam int BEATW  = LANES * DATAW;
  localparam int FRAMEW = N * DATAW;
  localparam int CNTW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

  packer_state_t       state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [FRAMEW-1:0]   fill_q, fill_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [FRAMEW-1:0]   frame;

  // State, beat count, fill buffer and output frame registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: capture beats in FILL, close the frame on the last
  // beat or in_last_i, and spend exactly one cycle in EMIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    data_d  = data_q;
    frame   = fill_q;
    case (state_q)
      ST_FILL: begin
        // Flush wins over acceptance and is honoured even while stalled.
        if (flush_i) begin
          cnt_d  = '0;
          fill_d = '0;
        end else if (en_i && in_valid_i) begin
          frame[int'(cnt_q) * BEATW +: BEATW] = in_data_i;
          if (in_last_i || (cnt_q == LAST_BEAT)) begin
            // Words past the closing beat are zeroed so a short frame
            // never carries stale lanes into the adder tree.
            for (int w = 0; w < N; w++) begin
              if (w >= (int'(cnt_q) + 1) * LANES) begin
                frame[w * DATAW +: DATAW] = '0;
              end
            end
            data_d  = OUT_WIDTH'(frame);
            fill_d  = '0;
            cnt_d   = '0;
            state_d = ST_EMIT;
          end else begin
            fill_d = frame;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        // Leaves unconditionally; en_i and flush_i cannot stretch or
        // cancel the strobe.
        state_d = ST_FILL;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  assign in_ready_o   = (state_q == ST_FILL) && en_i;
  assign data_o       = data_q;
  assign data_valid_o = (state_q == ST_EMIT);
  assign busy_o       = (cnt_q != '0);

endmodule : energy_operand_packer

// File: tb/tb_energy_operand_packer.sv
// Directed bench for energy_operand_packer with N=8, DATAW=8, LANES=2.
module tb_energy_operand_packer;

  localparam int N     = 8;
  localparam int DATAW = 8;
  localparam int LANES = 2;
  localparam int OUTW  = N * DATAW;

  logic              clk_i;
  logic              rst_i;
  logic              en_i;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [15:0]       in_data_i;
  logic              in_last_i;
  logic [OUTW-1:0]   data_o;
  logic              data_valid_o;
  logic              busy_o;

  int pass_count;
  int check_count;

  energy_operand_packer #(
    .N(N), .DATAW(DATAW), .LANES(LANES), .OUT_WIDTH(OUTW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_last_i(in_last_i), .data_o(data_o), .data_valid_o(data_valid_o),
    .busy_o(busy_o)
  );

  // Clock and reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one edge and settle; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    flush_i    = 1'b0;
    in_data_i  = '0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    en_i  = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check_count++;
    if (data_o !== 64'h0) $display("FAIL reset_data got=%h exp=%h", data_o, 64'h0);
    else pass_count++;
    check_count++;
    if (data_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL reset_flags got dv=%b busy=%b exp 0 0", data_valid_o, busy_o);
    else pass_count++;
    check_count++;
    if (in_ready_o !== 1'b0) $display("FAIL reset_ready_en0 got=%b exp=0", in_ready_o);
    else pass_count++;
    en_i = 1'b1;
    #1;
    check_count++;
    if (in_ready_o !== 1'b1) $display("FAIL reset_ready_en1 got=%b exp=1", in_ready_o);
    else pass_count++;
  endtask

  task automatic test_full_frame();
    send_beat(16'h0201, 1'b0);
    check_count++;
    if (busy_o !== 1'b1 || data_valid_o !== 1'b0)
      $display("FAIL full_busy got busy=%b dv=%b exp 1 0", busy_o, data_valid_o);
    else pass_count++;
    send_beat(16'h0403, 1'b0);
    send_beat(16'h0605, 1'b0);
    send_beat(16'h0807, 1'b0);
    check_count++;
    if (data_valid_o !== 1'b1 || in_ready_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL full_strobe got dv=%b rdy=%b busy=%b exp 1 0 0", data_valid_o, in_ready_o, busy_o);
    else pass_count++;
    check_count++;
    if (data_o !== 64'h0807060504030201)
      $display("FAIL full_data got=%h exp=%h", data_o, 64'h0807060504030201);
    else pass_count++;
    step();
    check_count++;
    if (data_valid_o !== 1'b0 || data_o !== 64'h0807060504030201 || in_ready_o !== 1'b1)
      $display("FAIL full_hold got dv=%b rdy=%b data=%h exp dv=0 rdy=1 data=%h",
               data_valid_o, in_ready_o, data_o, 64'h0807060504030201);
    else pass_count++;
  endtask

  task automatic test_last_early();
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b1);
    check_count++;
    if (data_valid_o !== 1'b1 || data_o !== 64'h0000000022221111)
      $display("FAIL last_early got dv=%b data=%h exp dv=1 data=%h",
               data_valid_o, data_o, 64'h0000000022221111);
    else pass_count++;
    step();
    check_count++;
    if (data_valid_o !== 1'b0) $display("FAIL last_early_single got dv=%b exp=0", data_valid_o);
    else pass_count++;
  endtask

  task automatic test_last_on_final_beat();
    send_beat(16'h1A0A, 1'b0);
    send_beat(16'h3B2B, 1'b0);
    send_beat(16'h5C4C, 1'b0);
    send_beat(16'h7D6D, 1'b1);
    check_count++;
    if (data_valid_o !== 1'b1 || data_o !== 64'h7D6D5C4C3B2B1A0A)
      $display("FAIL last_final got dv=%b data=%h exp dv=1 data=%h",
               data_valid_o, data_o, 64'h7D6D5C4C3B2B1A0A);
    else pass_count++;
    step();
  endtask

  task automatic test_flush();
    int strobes;
    strobes = 0;
    send_beat(16'hDEAD, 1'b0);
    send_beat(16'hBEEF, 1'b0);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 16'hCAFE;
    step();
    idle_inputs();
    check_count++;
    if (busy_o !== 1'b0 || data_valid_o !== 1'b0)
      $display("FAIL flush_clear got busy=%b dv=%b exp 0 0", busy_o, data_valid_o);
    else pass_count++;
    send_beat(16'hA1A0, 1'b0);
    if (data_valid_o) strobes++;
    send_beat(16'hA3A2, 1'b0);
    if (data_valid_o) strobes++;
    send_beat(16'hA5A4, 1'b0);
    if (data_valid_o) strobes++;
    send_beat(16'hA7A6, 1'b0);
    if (data_valid_o) strobes++;
    check_count++;
    if (data_valid_o !== 1'b1 || data_o !== 64'hA7A6A5A4A3A2A1A0)
      $display("FAIL flush_frame got dv=%b data=%h exp dv=1 data=%h",
               data_valid_o, data_o, 64'hA7A6A5A4A3A2A1A0);
    else pass_count++;
    // Flush during EMIT must not cancel the strobe already showing.
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    if (data_valid_o) strobes++;
    check_count++;
    if (strobes !== 1) $display("FAIL flush_strobes got=%0d exp=1", strobes);
    else pass_count++;
  endtask

  task automatic test_enable_stall();
    send_beat(16'h0B0A, 1'b0);
    send_beat(16'h0D0C, 1'b0);
    en_i       = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = 16'h0F0E;
    for (int i = 0; i < 3; i++) begin
      step();
      check_count++;
      if (in_ready_o !== 1'b0 || busy_o !== 1'b1 || data_valid_o !== 1'b0)
        $display("FAIL stall_cycle%0d got rdy=%b busy=%b dv=%b exp 0 1 0",
                 i, in_ready_o, busy_o, data_valid_o);
      else pass_count++;
    end
    en_i = 1'b1;
    step();
    send_beat(16'h1110, 1'b0);
    check_count++;
    if (data_valid_o !== 1'b1 || data_o !== 64'h11100F0E0D0C0B0A)
      $display("FAIL stall_frame got dv=%b data=%h exp dv=1 data=%h",
               data_valid_o, data_o, 64'h11100F0E0D0C0B0A);
    else pass_count++;
    step();
  endtask

  task automatic test_reset_mid_frame();
    int strobes;
    strobes = 0;
    send_beat(16'h5150, 1'b0);
    send_beat(16'h5352, 1'b0);
    send_beat(16'h5554, 1'b0);
    rst_i = 1'b1;
    #1;
    check_count++;
    if (data_o !== 64'h0 || busy_o !== 1'b0 || data_valid_o !== 1'b0)
      $display("FAIL midreset_async got data=%h busy=%b dv=%b exp 0 0 0",
               data_o, busy_o, data_valid_o);
    else pass_count++;
    #1;
    rst_i = 1'b0;
    step();
    if (data_valid_o) strobes++;
    send_beat(16'h6160, 1'b0);
    if (data_valid_o) strobes++;
    send_beat(16'h6362, 1'b0);
    if (data_valid_o) strobes++;
    send_beat(16'h6564, 1'b0);
    if (data_valid_o) strobes++;
    check_count++;
    if (strobes !== 0) $display("FAIL midreset_nostrobe got=%0d exp=0", strobes);
    else pass_count++;
    send_beat(16'h6766, 1'b0);
    check_count++;
    if (data_valid_o !== 1'b1 || data_o !== 64'h6766656463626160)
      $display("FAIL midreset_frame got dv=%b data=%h exp dv=1 data=%h",
               data_valid_o, data_o, 64'h6766656463626160);
    else pass_count++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] beats [8];
    int idx;
    int strobes;
    int first_cyc;
    int gap;
    logic rdy;
    beats[0] = 16'h1101; beats[1] = 16'h3322; beats[2] = 16'h5544; beats[3] = 16'h7766;
    beats[4] = 16'h9988; beats[5] = 16'hBBAA; beats[6] = 16'hDDCC; beats[7] = 16'hFFEE;
    idx = 0;
    strobes = 0;
    first_cyc = -1;
    gap = -1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      in_valid_i = (idx < 8);
      in_data_i  = beats[idx % 8];
      rdy = in_ready_o;
      step();
      if (rdy && idx < 8) idx++;
      if (data_valid_o) begin
        strobes++;
        if (strobes == 1) begin
          first_cyc = cyc;
          check_count++;
          if (data_o !== 64'h7766554433221101)
            $display("FAIL b2b_frame1 got=%h exp=%h", data_o, 64'h7766554433221101);
          else pass_count++;
        end else if (strobes == 2) begin
          gap = cyc - first_cyc;
          check_count++;
          if (data_o !== 64'hFFEEDDCCBBAA9988)
            $display("FAIL b2b_frame2 got=%h exp=%h", data_o, 64'hFFEEDDCCBBAA9988);
          else pass_count++;
        end
      end else if (strobes == 1) begin
        check_count++;
        if (data_o !== 64'h7766554433221101)
          $display("FAIL b2b_hold cyc%0d got=%h exp=%h", cyc, data_o, 64'h7766554433221101);
        else pass_count++;
      end
    end
    idle_inputs();
    check_count++;
    if (strobes !== 2 || gap !== 5)
      $display("FAIL b2b_spacing got strobes=%0d gap=%0d exp strobes=2 gap=5", strobes, gap);
    else pass_count++;
    check_count++;
    if (data_o !== 64'hFFEEDDCCBBAA9988)
      $display("FAIL b2b_final_hold got=%h exp=%h", data_o, 64'hFFEEDDCCBBAA9988);
    else pass_count++;
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    test_reset();
    test_full_frame();
    test_last_early();
    test_last_on_final_beat();
    test_flush();
    test_enable_stall();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule : tb_energy_operand_packer

// File: doc/energy_operand_packer.md
ENERGY_OPERAND_PACKER -- requirements
Module: energy_operand_packer

Interface
REQ-001 The block SHALL have parameter N, default 256, meaning operand words per packed frame.
REQ-002 The block SHALL have parameter DATAW, default 8, meaning bit width of each unsigned operand word.
REQ-003 The block SHALL have parameter LANES, default 4, meaning words accepted per input beat; N SHALL be a multiple of LANES and N/LANES SHALL be at least 2.
REQ-004 The block SHALL have parameter OUT_WIDTH, default N*DATAW, meaning packed output width.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port en_i, input, 1 bit: enable; low stalls acceptance and holds all state.
REQ-008 The block SHALL have port flush_i, input, 1 bit: discard the partial frame.
REQ-009 The block SHALL have port in_valid_i, input, 1 bit: input beat valid.
REQ-010 The block SHALL have port in_ready_o, output, 1 bit: input beat accepted when in_valid_i and in_ready_o are both high.
REQ-011 The block SHALL have port in_data_i, input, LANES*DATAW bits: lane l at bits [l*DATAW +: DATAW].
REQ-012 The block SHALL have port in_last_i, input, 1 bit: the beat closes the frame early.
REQ-013 The block SHALL have port data_o, output, OUT_WIDTH bits: packed frame, word w at bits [w*DATAW +: DATAW].
REQ-014 The block SHALL have port data_valid_o, output, 1 bit: single-cycle frame-complete strobe.
REQ-015 The block SHALL have port busy_o, output, 1 bit: high when the partial frame holds at least one beat.

Function
REQ-016 The block SHALL implement states FILL and EMIT; the reset state is FILL.
REQ-017 In FILL, in_ready_o SHALL equal en_i; in EMIT, in_ready_o SHALL be 0.
REQ-018 Accepted beat k (0-based, counted since frame start) SHALL write lane l into fill-buffer word k*LANES+l.
REQ-019 A beat count of 0..N/LANES-1 SHALL be kept and SHALL increment by one per accepted beat.
REQ-020 Accepting beat N/LANES-1, or any beat with in_last_i=1, SHALL move FILL->EMIT on the next edge.
REQ-021 On the FILL->EMIT edge, data_o SHALL load the fill buffer, with words at index >= (k+1)*LANES forced to zero.
REQ-022 On the same edge the beat count and fill buffer SHALL clear to zero.
REQ-023 data_valid_o SHALL be 1 exactly in the EMIT cycle, which is the cycle after the closing beat is accepted (latency 1).
REQ-024 EMIT->FILL SHALL occur unconditionally after one cycle, regardless of en_i.
REQ-025 data_o SHALL hold its value until the next EMIT load.
REQ-026 With en_i=0 in FILL, no beat SHALL be accepted and the beat count and buffer SHALL hold.
REQ-027 flush_i=1 in FILL SHALL clear the beat count and fill buffer, SHALL accept no beat that cycle, and SHALL produce no strobe.
REQ-028 flush_i=1 in EMIT SHALL NOT suppress the strobe already in progress.
REQ-029 A beat with in_last_i=1 at k=N/LANES-1 SHALL behave identically to a full frame.
REQ-030 busy_o SHALL equal (beat count != 0).
REQ-031 in_valid_i without in_ready_o SHALL have no effect, and the data SHALL not be captured.

Reset
REQ-032 rst_i=1 SHALL asynchronously force state FILL, beat count 0, fill buffer 0, data_o 0, data_valid_o 0 and busy_o 0.
REQ-033 After reset, in_ready_o SHALL equal en_i.
REQ-034 Reset mid-frame SHALL discard the partial frame with no strobe.

Structure
REQ-035 The state enum typedef and default constants for N, DATAW and LANES SHALL reside in the shared package energy_monitor_pkg.
REQ-036 The block SHALL be a single module with no sub-module; data_o and data_valid_o SHALL connect directly to the adder-tree data_i and data_valid_i.

Verification (N=8, DATAW=8, LANES=2)
REQ-037 Scenario: 4 back-to-back beats 0x0201, 0x0403, 0x0605, 0x0807 -> data_o=0x0807060504030201, one-cycle data_valid_o the cycle after beat 4, in_ready_o=0 that cycle.
REQ-038 Scenario: beats 0x1111, 0x2222 with in_last_i on the 2nd -> data_o=0x0000000022221111, strobe 1 cycle later.
REQ-039 Scenario: 2 beats, then flush_i, then 4 full beats -> exactly one strobe, carrying only the later 4 beats.
REQ-040 Scenario: en_i=0 for 3 cycles between beats 2 and 3 with in_valid_i held high -> no acceptance, count held, final data_o correct.
REQ-041 Scenario: rst_i asserted mid-cycle after 3 beats -> outputs zero immediately, no strobe, next 4 beats form a clean frame.
REQ-042 Scenario: two frames back-to-back with continuous in_valid_i -> strobes 5 cycles apart, each frame's data_o correct and held between strobes.
